// File: rtl/data_hamming_enc_fifo_pkg.sv
// Shared definitions for the 25-bit Hamming-protected region-readout word:
// field positions, parity masks and the parity helper.
package data_hamming_enc_fifo_pkg;

  localparam int unsigned DATA_W = 20;
  localparam int unsigned PAR_W  = 5;
  localparam int unsigned CODE_W = 25;
  localparam int unsigned TOT_W  = 4;

  localparam int unsigned LEFT_TOT_T_LSB  = 0;
  localparam int unsigned LEFT_TOT_B_LSB  = 4;
  localparam int unsigned RIGHT_TOT_T_LSB = 8;
  localparam int unsigned RIGHT_TOT_B_LSB = 12;
  localparam int unsigned LEFT_NEI_T_BIT  = 16;
  localparam int unsigned LEFT_NEI_B_BIT  = 17;
  localparam int unsigned RIGHT_NEI_T_BIT = 18;
  localparam int unsigned RIGHT_NEI_B_BIT = 19;

  localparam logic [TOT_W-1:0] EMPTY_TOT = 4'hF;

  // p1 deliberately leaves out data bit 17 to stay bit-exact with the receive checker
  localparam logic [DATA_W-1:0] P0_MASK = 20'hAAD5B;
  localparam logic [DATA_W-1:0] P1_MASK = 20'h1366D;
  localparam logic [DATA_W-1:0] P2_MASK = 20'h3C78E;
  localparam logic [DATA_W-1:0] P3_MASK = 20'hC07F0;
  localparam logic [DATA_W-1:0] P4_MASK = 20'hFF800;

  typedef logic [DATA_W-1:0] dataWord_t;
  typedef logic [CODE_W-1:0] codeWord_t;

  function automatic logic [PAR_W-1:0] calcParity(input dataWord_t d);
    return {^(d & P4_MASK), ^(d & P3_MASK), ^(d & P2_MASK),
            ^(d & P1_MASK), ^(d & P0_MASK)};
  endfunction

endpackage

// File: rtl/data_hamming_enc_fifo_if.sv
// Region word input stream and protected word output stream.
interface data_hamming_enc_fifo_if;
  import data_hamming_enc_fifo_pkg::*;

  logic             InValid;
  logic             InReady;
  logic             InLeft_NeiT;
  logic             InLeft_NeiB;
  logic             InRight_NeiT;
  logic             InRight_NeiB;
  logic [TOT_W-1:0] InLeft_TotT;
  logic [TOT_W-1:0] InLeft_TotB;
  logic [TOT_W-1:0] InRight_TotT;
  logic [TOT_W-1:0] InRight_TotB;
  logic             OutValid;
  logic             OutReady;
  codeWord_t        OutWord;

  modport master (
    output InValid, InLeft_NeiT, InLeft_NeiB, InRight_NeiT, InRight_NeiB,
           InLeft_TotT, InLeft_TotB, InRight_TotT, InRight_TotB, OutReady,
    input  InReady, OutValid, OutWord
  );

  modport slave (
    input  InValid, InLeft_NeiT, InLeft_NeiB, InRight_NeiT, InRight_NeiB,
           InLeft_TotT, InLeft_TotB, InRight_TotT, InRight_TotB, OutReady,
    output InReady, OutValid, OutWord
  );
endinterface

// File: rtl/data_hamming_enc_fifo_hamming_enc25.sv
// Pure combinational pack of one region's ToT/neighbour fields into 20 data bits
// plus 5 parity bits.
module hamming_enc25
  import data_hamming_enc_fifo_pkg::*;
(
  input  logic             leftNeiT,
  input  logic             leftNeiB,
  input  logic             rightNeiT,
  input  logic             rightNeiB,
  input  logic [TOT_W-1:0] leftTotT,
  input  logic [TOT_W-1:0] leftTotB,
  input  logic [TOT_W-1:0] rightTotT,
  input  logic [TOT_W-1:0] rightTotB,
  output codeWord_t        codeWord
);

  dataWord_t dataWord;

  always_comb begin
    dataWord = '0;
    dataWord[LEFT_TOT_T_LSB  +: TOT_W] = leftTotT;
    dataWord[LEFT_TOT_B_LSB  +: TOT_W] = leftTotB;
    dataWord[RIGHT_TOT_T_LSB +: TOT_W] = rightTotT;
    dataWord[RIGHT_TOT_B_LSB +: TOT_W] = rightTotB;
    dataWord[LEFT_NEI_T_BIT]  = leftNeiT;
    dataWord[LEFT_NEI_B_BIT]  = leftNeiB;
    dataWord[RIGHT_NEI_T_BIT] = rightNeiT;
    dataWord[RIGHT_NEI_B_BIT] = rightNeiB;
    codeWord = {calcParity(dataWord), dataWord};
  end

endmodule

// File: rtl/data_hamming_enc_fifo.sv
// Transmit side of the region-readout word: encode, optional empty-word drop,
// one-shot error injection, small output FIFO and saturating word/drop counters.
module data_hamming_enc_fifo
  import data_hamming_enc_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter bit          DROP_EMPTY = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  data_hamming_enc_fifo_if.slave  bus,
  input  logic                    InjArm,
  input  logic [4:0]              InjBit,
  output logic                    InjDone,
  output logic [CNT_W-1:0]        WordCount,
  output logic [CNT_W-1:0]        DropCount
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  codeWord_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;

  codeWord_t  encWord;
  codeWord_t  flipMask;
  codeWord_t  pushWord;
  logic       accept;
  logic       emptyWord;
  logic       push;
  logic       pop;
  logic       injArmed;
  logic [4:0] injBitQ;
  logic       effArmed;
  logic [4:0] effBit;

  hamming_enc25 uEnc (
    .leftNeiT  (bus.InLeft_NeiT),
    .leftNeiB  (bus.InLeft_NeiB),
    .rightNeiT (bus.InRight_NeiT),
    .rightNeiB (bus.InRight_NeiB),
    .leftTotT  (bus.InLeft_TotT),
    .leftTotB  (bus.InLeft_TotB),
    .rightTotT (bus.InRight_TotT),
    .rightTotB (bus.InRight_TotB),
    .codeWord  (encWord)
  );

  assign bus.InReady  = !Reset && (count < DEPTH_C);
  assign bus.OutValid = (count != '0);
  assign bus.OutWord  = mem[rdPtr];

  always_comb begin
    accept    = bus.InValid && bus.InReady;
    emptyWord = DROP_EMPTY
                && (bus.InLeft_TotT  == EMPTY_TOT) && (bus.InLeft_TotB  == EMPTY_TOT)
                && (bus.InRight_TotT == EMPTY_TOT) && (bus.InRight_TotB == EMPTY_TOT)
                && !bus.InLeft_NeiT && !bus.InLeft_NeiB
                && !bus.InRight_NeiT && !bus.InRight_NeiB;
    push      = accept && !emptyWord;
    pop       = (count != '0) && bus.OutReady;

    // An arm arriving together with a push applies to that push
    effArmed  = injArmed || InjArm;
    effBit    = InjArm ? InjBit : injBitQ;
    flipMask  = '0;
    if (effArmed && (effBit < 5'(CODE_W))) begin
      flipMask[effBit] = 1'b1;
    end
    pushWord  = encWord ^ flipMask;
    InjDone   = push && effArmed;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wrPtr] <= pushWord;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (!push && pop) begin
        count <= count - (PTR_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      injArmed <= 1'b0;
      injBitQ  <= '0;
    end else if (push && effArmed) begin
      injArmed <= 1'b0;
    end else if (InjArm) begin
      injArmed <= 1'b1;
      injBitQ  <= InjBit;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      WordCount <= '0;
      DropCount <= '0;
    end else begin
      if (push && (WordCount != '1)) begin
        WordCount <= WordCount + CNT_W'(1);
      end
      if (accept && emptyWord && (DropCount != '1)) begin
        DropCount <= DropCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_hamming_enc_fifo.sv
// Directed bench for data_hamming_enc_fifo: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_data_hamming_enc_fifo;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          InjArm;
  logic [4:0]    InjBit;
  logic          InjDone;
  logic [CW-1:0] WordCount;
  logic [CW-1:0] DropCount;

  int total = 0;
  int bad   = 0;

  data_hamming_enc_fifo_if bus ();

  data_hamming_enc_fifo #(.FIFO_DEPTH(DEPTH), .DROP_EMPTY(1'b1), .CNT_W(CW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .InjArm    (InjArm),
    .InjBit    (InjBit),
    .InjDone   (InjDone),
    .WordCount (WordCount),
    .DropCount (DropCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Parity columns written straight from the bit lists
  function automatic bit inCol(input int p, input int i);
    case (p)
      0: return i inside {0, 1, 3, 4, 6, 8, 10, 11, 13, 15, 17, 19};
      1: return i inside {0, 2, 3, 5, 6, 9, 10, 12, 13, 16};
      2: return i inside {1, 2, 3, 7, 8, 9, 10, 14, 15, 16, 17};
      3: return i inside {4, 5, 6, 7, 8, 9, 10, 18, 19};
      default: return (i >= 11) && (i <= 19);
    endcase
  endfunction

  function automatic logic [4:0] colOf(input int i);
    logic [4:0] c;
    for (int p = 0; p < 5; p++) c[p] = inCol(p, i);
    return c;
  endfunction

  function automatic logic [24:0] refEncode(input logic [19:0] d);
    logic [4:0] par;
    par = '0;
    for (int i = 0; i < 20; i++) if (d[i]) par = par ^ colOf(i);
    return {par, d};
  endfunction

  function automatic logic [19:0] refDecode(input logic [24:0] w);
    logic [24:0] re;
    logic [4:0]  syn;
    logic [19:0] d;
    re  = refEncode(w[19:0]);
    syn = re[24:20] ^ w[24:20];
    d   = w[19:0];
    if (syn != 5'd0)
      for (int i = 0; i < 20; i++) if (colOf(i) == syn) d[i] = ~d[i];
    return d;
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  logic [24:0] mq [$];
  logic        mArmed;
  logic [4:0]  mBit;
  int          mWc, mDc;
  logic [19:0] curD;
  logic        mReady, mAcc, mEmpty, mPush, mPop, mEff;
  logic [4:0]  mEffBit;
  logic [24:0] mWord;

  always @(negedge Clk) begin
    if (Reset) begin
      mq.delete();
      mArmed = 1'b0;
      mBit   = '0;
      mWc    = 0;
      mDc    = 0;
    end
    mReady = !Reset && (mq.size() < DEPTH);
    chk("InReady", bus.InReady, mReady);
    chk("OutValid", bus.OutValid, mq.size() != 0);
    if (mq.size() != 0) chk("OutWord", bus.OutWord, mq[0]);
    chk("WordCount", WordCount, mWc);
    chk("DropCount", DropCount, mDc);
    if (Reset) begin
      chk("OutWordRst", bus.OutWord, 0);
      chk("InjDoneRst", InjDone, 0);
    end else begin
      curD = {bus.InRight_NeiB, bus.InRight_NeiT, bus.InLeft_NeiB, bus.InLeft_NeiT,
              bus.InRight_TotB, bus.InRight_TotT, bus.InLeft_TotB, bus.InLeft_TotT};
      mAcc    = bus.InValid && mReady;
      mEmpty  = (curD[15:0] == 16'hFFFF) && (curD[19:16] == 4'h0);
      mPush   = mAcc && !mEmpty;
      mPop    = (mq.size() != 0) && bus.OutReady;
      mEff    = mArmed || InjArm;
      mEffBit = InjArm ? InjBit : mBit;
      chk("InjDone", InjDone, mPush && mEff);
      mWord = refEncode(curD);
      if (mEff && mEffBit < 25) mWord[mEffBit] = ~mWord[mEffBit];
      if (mPop) void'(mq.pop_front());
      if (mPush) begin
        mq.push_back(mWord);
        if (mWc < (1 << CW) - 1) mWc++;
      end
      if (mAcc && mEmpty && mDc < (1 << CW) - 1) mDc++;
      if (mPush && mEff) mArmed = 1'b0;
      else if (InjArm) begin
        mArmed = 1'b1;
        mBit   = InjBit;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyData(input logic [19:0] d);
    bus.InLeft_TotT  = d[3:0];
    bus.InLeft_TotB  = d[7:4];
    bus.InRight_TotT = d[11:8];
    bus.InRight_TotB = d[15:12];
    bus.InLeft_NeiT  = d[16];
    bus.InLeft_NeiB  = d[17];
    bus.InRight_NeiT = d[18];
    bus.InRight_NeiB = d[19];
  endtask

  task automatic send(input logic [19:0] d, output logic doneSeen);
    logic rdy;
    logic accepted;
    accepted = 1'b0;
    doneSeen = 1'b0;
    applyData(d);
    bus.InValid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      rdy      = bus.InReady;
      doneSeen = InjDone;
      step();
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    chk("accept", accepted, 1);
    bus.InValid = 1'b0;
  endtask

  task automatic arm(input logic [4:0] b);
    InjBit = b;
    InjArm = 1'b1;
    step();
    InjArm = 1'b0;
  endtask

  logic        dn;
  logic [24:0] e;
  logic [19:0] w5, w6;

  initial begin
    Reset = 1'b1;
    InjArm = 1'b0;
    InjBit = '0;
    bus.InValid = 1'b0;
    bus.OutReady = 1'b0;
    applyData(20'h0);
    w5 = 20'h0A3C5;
    w6 = 20'h51234;

    // pin the reference model itself
    chk("colBit0", colOf(0), 5'b00011);
    chk("colBit10", colOf(10), 5'b01111);
    chk("colBit17", colOf(17), 5'b10101);
    chk("colBit19", colOf(19), 5'b11001);
    chk("refEnc1", refEncode(20'h04321), 25'h1E04321);

    repeat (3) step();
    @(negedge Clk);
    chk("rstReady", bus.InReady, 0);
    chk("rstValid", bus.OutValid, 0);
    step();
    Reset = 1'b0;
    @(negedge Clk);
    chk("readyAfterRst", bus.InReady, 1);
    step();

    // 1: basic word, visible the cycle after acceptance
    send(20'h04321, dn);
    @(negedge Clk);
    chk("t1Valid", bus.OutValid, 1);
    chk("t1Word", bus.OutWord, 25'h1E04321);
    step();
    bus.OutReady = 1'b1;
    step();

    // 2: one-hot data bits
    for (int i = 0; i < 20; i++) begin
      send(20'h1 << i, dn);
      @(negedge Clk);
      chk("colParity", bus.OutWord[24:20], colOf(i));
      chk("roundTrip", refDecode(bus.OutWord), 20'h1 << i);
    end
    step();
    step();
    chk("wcSaturated", WordCount, 4'hF);

    // 3: fill with consumer stalled, then drain in order
    bus.OutReady = 1'b0;
    send(20'h11111, dn);
    send(20'h22222, dn);
    @(negedge Clk);
    chk("fullNotReady", bus.InReady, 0);
    fork
      send(20'h33333, dn);
      begin
        repeat (3) step();
        bus.OutReady = 1'b1;
      end
    join
    repeat (4) step();
    chk("drainedReady", bus.InReady, 1);
    chk("drainedValid", bus.OutValid, 0);

    // 4: empty word dropped
    send(20'h0FFFF, dn);
    @(negedge Clk);
    chk("dropNoValid", bus.OutValid, 0);
    chk("dropCount", DropCount, 1);
    step();

    // 5: error injection
    arm(5'd5);
    send(w5, dn);
    chk("injDone5", dn, 1);
    @(negedge Clk);
    e = refEncode(w5);
    e[5] = ~e[5];
    chk("inj5Word", bus.OutWord, e);
    step();
    send(w6, dn);
    chk("cleanDone", dn, 0);
    @(negedge Clk);
    chk("cleanWord", bus.OutWord, refEncode(w6));
    step();
    arm(5'd30);
    send(w5, dn);
    chk("injDone30", dn, 1);
    @(negedge Clk);
    chk("inj30Word", bus.OutWord, refEncode(w5));
    step();
    arm(5'd7);
    send(20'h0FFFF, dn);
    chk("dropKeepsArm", dn, 0);
    send(w6, dn);
    @(negedge Clk);
    e = refEncode(w6);
    e[7] = ~e[7];
    chk("inj7Word", bus.OutWord, e);
    step();
    InjBit = 5'd22;
    InjArm = 1'b1;
    send(w5, dn);
    InjArm = 1'b0;
    chk("sameCycleDone", dn, 1);
    @(negedge Clk);
    e = refEncode(w5);
    e[22] = ~e[22];
    chk("sameCycleWord", bus.OutWord, e);
    step();

    // 6: reset with queued words and pending arm
    bus.OutReady = 1'b0;
    send(w5, dn);
    send(w6, dn);
    arm(5'd3);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midRstValid", bus.OutValid, 0);
    chk("midRstWc", WordCount, 0);
    chk("midRstDc", DropCount, 0);
    step();
    Reset = 1'b0;
    step();
    send(w6, dn);
    chk("postRstDone", dn, 0);
    @(negedge Clk);
    chk("postRstWord", bus.OutWord, refEncode(w6));
    chk("postRstWc", WordCount, 1);
    bus.OutReady = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
